l2t_sii_req_rcv: RTL and testbench
==================================

Name: l2t_sii_req_rcv

Overview:
- L2 tag-side receiver for the SII-to-L2T inbound request interface; one instance per L2 bank.
- Deserialises the 32-bit request stream into 64-bit headers and optional write data.
- Queues requests in arrival order and presents them to the L2T pipe.
- Returns the per-bank dequeue strobes to SII: iq_dequeue for READ/WR8, wib_dequeue for WRI.

Parameters:
- IQ_DEPTH, 4, input-queue entries (headers plus WR8 data); power of 2, minimum 2.
- WIB_DEPTH, 2, write-invalidate buffer entries, 64 bytes each; power of 2.

Ports:
- iol2clk  in  1  interface clock; all logic on the rising edge.
- arst_l  in  1  asynchronous active-low reset.
- sii_l2t_req_vld  in  1  one-cycle pulse marking the start of a packet.
- sii_l2t_req  in  32  packet payload stream.
- l2_req_vld  out  1  head-of-queue request valid.
- l2_req_rdy  in  1  L2T pipe accepts the head request.
- l2_req_hdr  out  64  header of the head request.
- l2_req_wr8_data  out  64  WR8 data; 0 for other commands.
- l2_req_wri_data  out  512  WRI line from the WIB head; 0 for other commands.
- l2t_sii_iq_dequeue  out  1  one-cycle pulse: READ or WR8 popped.
- l2t_sii_wib_dequeue  out  1  one-cycle pulse: WRI popped and its 64 bytes drained.
- rcv_err  out  1  sticky error flag.

Behaviour:
- Packet timing, with vld asserted in cycle N:
  - N+1: hdr[63:32].
  - N+2: hdr[31:0].
  - N+3: dummy cycle, ignored.
  - N+4 onward: data beats, most significant word first.
- Command decode from hdr[63:61]:
  - 3'b001 READ: 0 data beats.
  - 3'b010 WR8: 2 beats.
  - 3'b100 WRI: 16 beats.
  - Any other value: illegal. Set rcv_err, consume 0 data beats, enqueue nothing.
- Receive FSM states: IDLE, HDR0, HDR1, DUMMY, DATA, COMMIT.
  - IDLE to HDR0 on vld; HDR0 to HDR1 to DUMMY unconditionally.
  - DUMMY goes to DATA if beats > 0, otherwise to COMMIT.
  - DATA uses a 4-bit beat counter and goes to COMMIT after the final beat.
  - COMMIT writes the entry and returns to IDLE. It lasts exactly 1 cycle.
- Minimum packet spacing is therefore 5 cycles for READ, 7 for WR8, 21 for WRI.
- vld outside IDLE is a protocol error: set rcv_err and ignore the pulse. The packet in flight continues.
- Input queue:
  - FIFO with IQ_DEPTH entries; each entry holds hdr, wr8 data, an is_wri bit and a wib index.
  - WRI data streams directly into the WIB slot at the WIB write pointer.
  - In COMMIT, the IQ write pointer advances. For WRI, the WIB write pointer also advances.
- Overflow:
  - Condition: COMMIT with IQ full, or a WRI COMMIT with WIB full. SII credit rules forbid this.
  - Required response: drop the packet, set rcv_err, leave all queue state unchanged.
- Output:
  - l2_req_vld = IQ non-empty.
  - hdr, wr8_data and wri_data are driven combinationally from the head entry. Unused data outputs read 0.
  - Pop occurs when l2_req_vld && l2_req_rdy.
  - Pop of a READ/WR8 entry: l2t_sii_iq_dequeue pulses 1 cycle.
  - Pop of a WRI entry: l2t_sii_wib_dequeue pulses 1 cycle and the WIB read pointer advances.
  - Both strobes are registered and assert in the cycle after the pop.
- Simultaneous COMMIT and pop on a full queue: the pop frees the slot in the same cycle, so the push succeeds with no overflow. Occupancy is unchanged.
- Pointers are log2(depth)+1 bits wide. Full and empty come from MSB/index compare. Wrap-around is natural.
- Latency: a packet is visible on l2_req_vld 1 cycle after COMMIT. A READ with vld at N gives l2_req_vld at N+5.
- Reset (arst_l low, asynchronous), values:
  - FSM = IDLE; all pointers and counters = 0.
  - l2_req_vld = 0, both dequeue strobes = 0, rcv_err = 0.
  - Data outputs = 0; queue storage is not reset.
- Reset mid-packet: the partial packet is discarded. Reception restarts at the next vld after deassertion.
- rcv_err clears only on reset.

Test Plan:
- READ: vld, then 0x2000_0012 / 0x3400_0040, dummy, rdy=1.
  - l2_req_vld at N+5, hdr=0x2000_0012_3400_0040.
  - iq_dequeue pulses at N+6; wib_dequeue stays 0.
- WR8: hdr 0x4000_0000_0000_1008, data 0xDEAD_BEEF / 0xCAFE_F00D.
  - wr8_data=0xDEADBEEFCAFEF00D at N+7; iq_dequeue pulses on pop.
- WRI: data beats 0x0..0xF.
  - wri_data[511:480]=0, wri_data[31:0]=0xF.
  - wib_dequeue pulses exactly once on pop.
- Back-pressure: rdy=0, send 4 READs, then a 5th.
  - Queue holds 4; the 5th sets rcv_err=1 and is dropped.
  - Raising rdy drains the 4 in order with 4 iq_dequeue pulses.
- Full queue with COMMIT and pop in the same cycle: no error, occupancy stays 4, order preserved.
- Illegal command 3'b111 sets rcv_err with no enqueue.
- arst_l pulsed low during a WRI data beat: all outputs 0. A following READ is received correctly.

Source files
------------

// File: rtl/l2t_sii_req_rcv.sv
`default_nettype none
// ============================================================================
//  Module   : l2t_sii_req_rcv
//  Function : SII-to-L2T inbound request receiver for one L2 bank.
//             Deserialises the 32-bit request stream into a 64-bit header
//             plus optional WR8 / WRI data, queues requests in arrival
//             order and presents the head entry to the L2T pipe.
//             Dequeue strobes go back to SII as credit returns.
//  Revision : 1.0  initial release
// ============================================================================
module l2t_sii_req_rcv #(
    parameter int IQ_DEPTH  = 4,   // input-queue entries, power of 2, >= 2
    parameter int WIB_DEPTH = 2    // 64-byte write-invalidate lines, power of 2
) (
    input  logic         iol2clk,
    input  logic         arst_l,
    input  logic         sii_l2t_req_vld,
    input  logic [31:0]  sii_l2t_req,
    output logic         l2_req_vld,
    input  logic         l2_req_rdy,
    output logic [63:0]  l2_req_hdr,
    output logic [63:0]  l2_req_wr8_data,
    output logic [511:0] l2_req_wri_data,
    output logic         l2t_sii_iq_dequeue,
    output logic         l2t_sii_wib_dequeue,
    output logic         rcv_err
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int IQ_AW     = $clog2(IQ_DEPTH);
    localparam int WIB_AW    = $clog2(WIB_DEPTH);
    localparam int WIB_WORDS = WIB_DEPTH * 16;

    localparam logic [2:0] CMD_READ = 3'b001;
    localparam logic [2:0] CMD_WR8  = 3'b010;
    localparam logic [2:0] CMD_WRI  = 3'b100;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_HDR0   = 3'd1;
    localparam logic [2:0] S_HDR1   = 3'd2;
    localparam logic [2:0] S_DUMMY  = 3'd3;
    localparam logic [2:0] S_DATA   = 3'd4;
    localparam logic [2:0] S_COMMIT = 3'd5;

    localparam logic [IQ_AW:0]  IQ_PTR_ONE  = {{IQ_AW{1'b0}}, 1'b1};
    localparam logic [WIB_AW:0] WIB_PTR_ONE = {{WIB_AW{1'b0}}, 1'b1};

    // ------------------------------------------------------------------------
    // Receive-side state
    // ------------------------------------------------------------------------
    logic [2:0]  r_state;
    logic [2:0]  w_state_nxt;
    logic [63:0] r_hdr;          // header under assembly
    logic [63:0] r_wr8;          // WR8 data shift register, MSW first
    logic [3:0]  r_beat_cnt;     // index of the current data beat
    logic [3:0]  r_beat_last;    // index of the final data beat

    // FSM output strobes
    logic w_cap_hi;
    logic w_cap_lo;
    logic w_decode;
    logic w_beat;
    logic w_commit;

    // Command decode of the assembled header
    logic [2:0] w_cmd;
    logic       w_is_read;
    logic       w_is_wr8;
    logic       w_is_wri;
    logic       w_legal;
    logic [4:0] w_nbeats;

    // ------------------------------------------------------------------------
    // Queue state and storage (storage is deliberately not reset)
    // ------------------------------------------------------------------------
    logic [IQ_AW:0]    r_iq_wptr;
    logic [IQ_AW:0]    r_iq_rptr;
    logic [WIB_AW:0]   r_wib_wptr;
    logic [WIB_AW:0]   r_wib_rptr;

    logic [63:0]       r_iq_hdr  [IQ_DEPTH];
    logic [63:0]       r_iq_wr8  [IQ_DEPTH];
    logic              r_iq_wri  [IQ_DEPTH];
    logic [WIB_AW-1:0] r_iq_widx [IQ_DEPTH];
    logic [31:0]       r_wib_mem [WIB_WORDS];

    logic              r_iq_deq;
    logic              r_wib_deq;
    logic              r_err;

    logic [IQ_AW-1:0]  w_iq_widx;
    logic [IQ_AW-1:0]  w_iq_ridx;
    logic              w_iq_empty;
    logic              w_iq_full;
    logic              w_wib_full;
    logic              w_head_wri;
    logic [WIB_AW-1:0] w_head_widx;
    logic              w_pop;
    logic              w_iq_room;
    logic              w_wib_room;
    logic              w_push;
    logic              w_drop;
    logic              w_proto_err;
    logic              w_wib_wr;
    logic [WIB_AW+3:0] w_wib_waddr;
    logic [511:0]      w_wri_line;

    // ------------------------------------------------------------------------
    // Command decode
    // ------------------------------------------------------------------------
    assign w_cmd     = r_hdr[63:61];
    assign w_is_read = (w_cmd == CMD_READ);
    assign w_is_wr8  = (w_cmd == CMD_WR8);
    assign w_is_wri  = (w_cmd == CMD_WRI);
    assign w_legal   = w_is_read | w_is_wr8 | w_is_wri;

    // Number of data beats that follow the dummy cycle for this command
    always_comb begin
        w_nbeats = 5'd0;
        if (w_is_wr8) begin
            w_nbeats = 5'd2;
        end else if (w_is_wri) begin
            w_nbeats = 5'd16;
        end
    end

    // ------------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------------
    // State register
    always_ff @(posedge iol2clk or negedge arst_l) begin
        if (!arst_l) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: fixed header/dummy slots, then a counted data phase
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (sii_l2t_req_vld) w_state_nxt = S_HDR0;
            S_HDR0:   w_state_nxt = S_HDR1;
            S_HDR1:   w_state_nxt = S_DUMMY;
            S_DUMMY:  w_state_nxt = (w_nbeats != 5'd0) ? S_DATA : S_COMMIT;
            S_DATA:   if (r_beat_cnt == r_beat_last) w_state_nxt = S_COMMIT;
            S_COMMIT: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Output decode: one strobe per receive phase
    always_comb begin
        w_cap_hi = 1'b0;
        w_cap_lo = 1'b0;
        w_decode = 1'b0;
        w_beat   = 1'b0;
        w_commit = 1'b0;
        case (r_state)
            S_HDR0:   w_cap_hi = 1'b1;
            S_HDR1:   w_cap_lo = 1'b1;
            S_DUMMY:  w_decode = 1'b1;
            S_DATA:   w_beat   = 1'b1;
            S_COMMIT: w_commit = 1'b1;
            default:  ;
        endcase
    end

    // ------------------------------------------------------------------------
    // Receive datapath
    // ------------------------------------------------------------------------
    // Header assembly, upper word arrives first
    always_ff @(posedge iol2clk or negedge arst_l) begin
        if (!arst_l) begin
            r_hdr <= '0;
        end else if (w_cap_hi) begin
            r_hdr[63:32] <= sii_l2t_req;
        end else if (w_cap_lo) begin
            r_hdr[31:0] <= sii_l2t_req;
        end
    end

    // Beat counter, armed in the dummy cycle once the command is known
    always_ff @(posedge iol2clk or negedge arst_l) begin
        if (!arst_l) begin
            r_beat_cnt  <= 4'd0;
            r_beat_last <= 4'd0;
        end else if (w_decode) begin
            r_beat_cnt  <= 4'd0;
            r_beat_last <= 4'(w_nbeats - 5'd1);
        end else if (w_beat) begin
            r_beat_cnt  <= r_beat_cnt + 4'd1;
        end
    end

    // WR8 data collects MSW first through a two-word shift
    always_ff @(posedge iol2clk or negedge arst_l) begin
        if (!arst_l) begin
            r_wr8 <= '0;
        end else if (w_beat && w_is_wr8) begin
            r_wr8 <= {r_wr8[31:0], sii_l2t_req};
        end
    end

    // ------------------------------------------------------------------------
    // Queue control
    // ------------------------------------------------------------------------
    assign w_iq_widx  = r_iq_wptr[IQ_AW-1:0];
    assign w_iq_ridx  = r_iq_rptr[IQ_AW-1:0];
    assign w_iq_empty = (r_iq_wptr == r_iq_rptr);
    assign w_iq_full  = (r_iq_wptr[IQ_AW] != r_iq_rptr[IQ_AW]) &&
                        (w_iq_widx == w_iq_ridx);
    assign w_wib_full = (r_wib_wptr[WIB_AW] != r_wib_rptr[WIB_AW]) &&
                        (r_wib_wptr[WIB_AW-1:0] == r_wib_rptr[WIB_AW-1:0]);

    assign w_head_wri  = r_iq_wri[w_iq_ridx];
    assign w_head_widx = r_iq_widx[w_iq_ridx];
    assign w_pop       = !w_iq_empty && l2_req_rdy;

    // A pop in the commit cycle frees its slot in time for the push
    assign w_iq_room  = !w_iq_full || w_pop;
    assign w_wib_room = !w_wib_full || (w_pop && w_head_wri);
    assign w_push     = w_commit && w_legal && w_iq_room && (!w_is_wri || w_wib_room);
    assign w_drop     = w_commit && !w_push;
    assign w_proto_err = sii_l2t_req_vld && (r_state != S_IDLE);

    // WRI beats stream straight into the free WIB slot; a full WIB would
    // alias the oldest queued line, so those beats are discarded
    assign w_wib_wr    = w_beat && w_is_wri && !w_wib_full;
    assign w_wib_waddr = {r_wib_wptr[WIB_AW-1:0], ~r_beat_cnt};

    // Pointer update on push and pop
    always_ff @(posedge iol2clk or negedge arst_l) begin
        if (!arst_l) begin
            r_iq_wptr  <= '0;
            r_iq_rptr  <= '0;
            r_wib_wptr <= '0;
            r_wib_rptr <= '0;
        end else begin
            if (w_push) begin
                r_iq_wptr <= r_iq_wptr + IQ_PTR_ONE;
                if (w_is_wri) begin
                    r_wib_wptr <= r_wib_wptr + WIB_PTR_ONE;
                end
            end
            if (w_pop) begin
                r_iq_rptr <= r_iq_rptr + IQ_PTR_ONE;
                if (w_head_wri) begin
                    r_wib_rptr <= r_wib_rptr + WIB_PTR_ONE;
                end
            end
        end
    end

    // Entry and WIB storage writes
    always_ff @(posedge iol2clk) begin
        if (w_push) begin
            r_iq_hdr[w_iq_widx]  <= r_hdr;
            r_iq_wr8[w_iq_widx]  <= w_is_wr8 ? r_wr8 : 64'd0;
            r_iq_wri[w_iq_widx]  <= w_is_wri;
            r_iq_widx[w_iq_widx] <= r_wib_wptr[WIB_AW-1:0];
        end
        if (w_wib_wr) begin
            r_wib_mem[w_wib_waddr] <= sii_l2t_req;
        end
    end

    // Registered credit-return strobes and the sticky error flag
    always_ff @(posedge iol2clk or negedge arst_l) begin
        if (!arst_l) begin
            r_iq_deq  <= 1'b0;
            r_wib_deq <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_iq_deq  <= w_pop && !w_head_wri;
            r_wib_deq <= w_pop && w_head_wri;
            r_err     <= r_err | w_proto_err | w_drop;
        end
    end

    // ------------------------------------------------------------------------
    // Head-entry presentation
    // ------------------------------------------------------------------------
    // Word 15 of a slot holds the first beat, so it lands in bits [511:480]
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_wri_line
            assign w_wri_line[gi*32 +: 32] = r_wib_mem[{w_head_widx, 4'(gi)}];
        end
    endgenerate

    assign l2_req_vld          = !w_iq_empty;
    assign l2_req_hdr          = l2_req_vld ? r_iq_hdr[w_iq_ridx] : 64'd0;
    assign l2_req_wr8_data     = l2_req_vld ? r_iq_wr8[w_iq_ridx] : 64'd0;
    assign l2_req_wri_data     = (l2_req_vld && w_head_wri) ? w_wri_line : 512'd0;
    assign l2t_sii_iq_dequeue  = r_iq_deq;
    assign l2t_sii_wib_dequeue = r_wib_deq;
    assign rcv_err             = r_err;

endmodule
`default_nettype wire

// File: tb/tb_l2t_sii_req_rcv.sv
`default_nettype none
// ============================================================================
//  Module   : tb_l2t_sii_req_rcv
//  Function : Self-checking bench for l2t_sii_req_rcv: directed vector table,
//             hand-written multi-cycle corner cases, and a randomized run
//             against a transaction-level queue model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_l2t_sii_req_rcv;

    localparam int IQ_D  = 4;
    localparam int WIB_D = 2;

    logic         iol2clk;
    logic         arst_l;
    logic         vld;
    logic [31:0]  req;
    logic         rdy;
    logic         o_vld;
    logic [63:0]  o_hdr;
    logic [63:0]  o_wr8;
    logic [511:0] o_wri;
    logic         o_iqdq;
    logic         o_wibdq;
    logic         o_err;

    int n_chk = 0;
    int n_err = 0;

    l2t_sii_req_rcv #(.IQ_DEPTH(IQ_D), .WIB_DEPTH(WIB_D)) u_dut (
        .iol2clk             (iol2clk),
        .arst_l              (arst_l),
        .sii_l2t_req_vld     (vld),
        .sii_l2t_req         (req),
        .l2_req_vld          (o_vld),
        .l2_req_rdy          (rdy),
        .l2_req_hdr          (o_hdr),
        .l2_req_wr8_data     (o_wr8),
        .l2_req_wri_data     (o_wri),
        .l2t_sii_iq_dequeue  (o_iqdq),
        .l2t_sii_wib_dequeue (o_wibdq),
        .rcv_err             (o_err)
    );

    initial iol2clk = 1'b0;
    always #5 iol2clk = ~iol2clk;

    // ------------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------------
    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge iol2clk);
        #1;
    endtask

    task automatic do_reset();
        arst_l = 1'b0;
        vld    = 1'b0;
        rdy    = 1'b0;
        req    = '0;
        tick();
        tick();
        arst_l = 1'b1;
        tick();
    endtask

    // Drives a full packet starting with vld in the current cycle; returns
    // in the commit cycle (vld cycle + 4 + beats)
    task automatic send_pkt(input logic [63:0] hdr, input logic [511:0] data, input int nb);
        vld = 1'b1; req = $urandom; tick();
        vld = 1'b0; req = hdr[63:32]; tick();
        req = hdr[31:0]; tick();
        req = $urandom; tick();
        for (int k = 0; k < nb; k++) begin
            req = data[511-32*k -: 32];
            tick();
        end
        req = $urandom;
    endtask

    logic [63:0] exp_hdrs[$];

    // Pops every queued entry with rdy held high, checking order and strobes
    task automatic drain_check(input string nm);
        int n;
        int cnt;
        n   = exp_hdrs.size();
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_hdr%0d", nm, i), o_hdr, exp_hdrs[i]);
            rdy = 1'b1;
            tick();
            cnt += int'(o_iqdq);
        end
        rdy = 1'b0;
        chk($sformatf("%s_empty", nm), o_vld, 1'b0);
        chk($sformatf("%s_deq_cnt", nm), cnt, n);
        tick();
        chk($sformatf("%s_deq_idle", nm), o_iqdq, 1'b0);
    endtask

    // ------------------------------------------------------------------------
    // Directed vector table
    // ------------------------------------------------------------------------
    typedef struct {
        string        name;
        logic [63:0]  hdr;
        logic [511:0] data;
        int           nb;
        logic         exp_vld;
        logic [63:0]  exp_hdr;
        logic [63:0]  exp_wr8;
        logic [31:0]  exp_wri_hi;
        logic [31:0]  exp_wri_lo;
        logic         exp_err;
        logic         exp_iqdq;
        logic         exp_wibdq;
    } vec_t;

    vec_t vecs[6];

    // ------------------------------------------------------------------------
    // Reference-model types for the random run
    // ------------------------------------------------------------------------
    typedef struct {
        logic [63:0]  hdr;
        logic [63:0]  wr8;
        logic [511:0] wri;
        logic         is_wri;
        logic         legal;
        logic         complete;
    } pkt_t;

    pkt_t pk[$];
    pkt_t mq[$];
    logic s_vld[$];
    logic [31:0] s_req[$];
    int   s_commit[$];
    int   s_beat[$];

    initial begin
        logic [511:0] ramp;
        logic [63:0]  h;
        int           np;
        logic         m_err;
        logic         m_iqdq;
        logic         m_wibdq;

        for (int k = 0; k < 16; k++) ramp[511-32*k -: 32] = 32'(k);

        vecs[0] = '{"read",  64'h2000_0012_3400_0040, 512'd0, 0,
                    1'b1, 64'h2000_0012_3400_0040, 64'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{"wr8",   64'h4000_0000_0000_1008, {64'hDEAD_BEEF_CAFE_F00D, 448'd0}, 2,
                    1'b1, 64'h4000_0000_0000_1008, 64'hDEAD_BEEF_CAFE_F00D, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{"wri",   64'h8000_0000_0000_0040, ramp, 16,
                    1'b1, 64'h8000_0000_0000_0040, 64'd0, 32'h0, 32'hF, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{"ill7",  64'hE000_0000_0000_0080, 512'd0, 0,
                    1'b0, 64'd0, 64'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{"ill0",  64'h0000_0000_1234_5678, 512'd0, 0,
                    1'b0, 64'd0, 64'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{"wr8b",  64'h5FFF_0000_0000_2000, {64'h0123_4567_89AB_CDEF, 448'd0}, 2,
                    1'b1, 64'h5FFF_0000_0000_2000, 64'h0123_4567_89AB_CDEF, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0};

        // Reset state, checked while reset is held
        arst_l = 1'b0; vld = 1'b0; rdy = 1'b0; req = '0;
        #12;
        chk("rst_vld",   o_vld,   1'b0);
        chk("rst_hdr",   o_hdr,   64'd0);
        chk("rst_wr8",   o_wr8,   64'd0);
        chk("rst_wri",   o_wri,   512'd0);
        chk("rst_iqdq",  o_iqdq,  1'b0);
        chk("rst_wibdq", o_wibdq, 1'b0);
        chk("rst_err",   o_err,   1'b0);

        // ---------------- table-driven single packets ----------------
        for (int i = 0; i < 6; i++) begin
            do_reset();
            send_pkt(vecs[i].hdr, vecs[i].data, vecs[i].nb);
            chk({vecs[i].name, "_early"}, o_vld, 1'b0);
            tick();
            chk({vecs[i].name, "_vld"},    o_vld, vecs[i].exp_vld);
            chk({vecs[i].name, "_hdr"},    o_hdr, vecs[i].exp_hdr);
            chk({vecs[i].name, "_wr8"},    o_wr8, vecs[i].exp_wr8);
            chk({vecs[i].name, "_wri_hi"}, o_wri[511:480], vecs[i].exp_wri_hi);
            chk({vecs[i].name, "_wri_lo"}, o_wri[31:0], vecs[i].exp_wri_lo);
            chk({vecs[i].name, "_err"},    o_err, vecs[i].exp_err);
            if (vecs[i].nb == 16) chk({vecs[i].name, "_wri_all"}, o_wri, vecs[i].data);
            rdy = 1'b1;
            tick();
            rdy = 1'b0;
            chk({vecs[i].name, "_iqdq"},  o_iqdq,  vecs[i].exp_iqdq);
            chk({vecs[i].name, "_wibdq"}, o_wibdq, vecs[i].exp_wibdq);
            tick();
            chk({vecs[i].name, "_iqdq_pulse"},  o_iqdq,  1'b0);
            chk({vecs[i].name, "_wibdq_pulse"}, o_wibdq, 1'b0);
            chk({vecs[i].name, "_popped"},      o_vld,   1'b0);
        end

        // ---------------- back-pressure and overflow ----------------
        do_reset();
        exp_hdrs.delete();
        for (int i = 0; i < 4; i++) begin
            h = {32'h2000_0100 + 32'(i), 32'h0000_0040 + 32'(i)};
            exp_hdrs.push_back(h);
            send_pkt(h, 512'd0, 0);
            tick();
        end
        chk("bp_full_err", o_err, 1'b0);
        chk("bp_full_vld", o_vld, 1'b1);
        send_pkt(64'h2000_0999_0000_0099, 512'd0, 0);
        tick();
        chk("bp_ovf_err", o_err, 1'b1);
        drain_check("bp");

        // ---------------- full queue: commit and pop together ----------------
        do_reset();
        exp_hdrs.delete();
        for (int i = 0; i < 4; i++) begin
            h = {32'h2000_0A00 + 32'(i), 32'h0000_1000 + 32'(i)};
            exp_hdrs.push_back(h);
            send_pkt(h, 512'd0, 0);
            tick();
        end
        h = 64'h2000_0A0E_0000_100E;
        send_pkt(h, 512'd0, 0);
        rdy = 1'b1;           // pop lands in the commit cycle
        tick();
        rdy = 1'b0;
        void'(exp_hdrs.pop_front());
        exp_hdrs.push_back(h);
        chk("sim_err", o_err, 1'b0);
        chk("sim_iqdq", o_iqdq, 1'b1);
        drain_check("sim");

        // ---------------- vld while a packet is in flight ----------------
        do_reset();
        vld = 1'b1; req = $urandom; tick();
        vld = 1'b0; req = 32'h2000_0055; tick();
        vld = 1'b1; req = 32'h0000_0077; tick();
        vld = 1'b0; req = $urandom; tick();
        tick();
        chk("proto_vld", o_vld, 1'b1);
        chk("proto_hdr", o_hdr, 64'h2000_0055_0000_0077);
        chk("proto_err", o_err, 1'b1);

        // ---------------- asynchronous reset during a WRI beat ----------------
        do_reset();
        send_pkt(64'hE000_0000_0000_0000, 512'd0, 0);
        tick();
        send_pkt(64'h2000_0000_0000_0001, 512'd0, 0);
        tick();
        chk("ar_pre_vld", o_vld, 1'b1);
        chk("ar_pre_err", o_err, 1'b1);
        vld = 1'b1; req = $urandom; tick();
        vld = 1'b0; req = 32'h8000_0000; tick();
        req = 32'h0000_0000; tick();
        req = $urandom; tick();
        for (int k = 0; k < 5; k++) begin req = 32'(k); tick(); end
        #2 arst_l = 1'b0;
        #1;
        chk("ar_vld",   o_vld,   1'b0);
        chk("ar_hdr",   o_hdr,   64'd0);
        chk("ar_wr8",   o_wr8,   64'd0);
        chk("ar_wri",   o_wri,   512'd0);
        chk("ar_iqdq",  o_iqdq,  1'b0);
        chk("ar_wibdq", o_wibdq, 1'b0);
        chk("ar_err",   o_err,   1'b0);
        tick();
        arst_l = 1'b1;
        for (int k = 5; k < 11; k++) begin req = 32'(k); tick(); end
        chk("ar_idle_vld", o_vld, 1'b0);
        send_pkt(64'h2000_0123_0000_0456, 512'd0, 0);
        tick();
        chk("ar_rd_vld", o_vld, 1'b1);
        chk("ar_rd_hdr", o_hdr, 64'h2000_0123_0000_0456);
        chk("ar_rd_err", o_err, 1'b0);

        // ---------------- randomized run against the queue model ----------------
        do_reset();
        np = 80;
        for (int p = 0; p < np; p++) begin
            pkt_t  pt;
            int    kind;
            int    nb;
            int    gap;
            logic [2:0] cmd;
            kind = $urandom_range(0, 9);
            if (kind < 3)      cmd = 3'b001;
            else if (kind < 6) cmd = 3'b010;
            else if (kind < 9) cmd = 3'b100;
            else begin
                cmd = 3'($urandom_range(0, 7));
                while (cmd == 3'b001 || cmd == 3'b010 || cmd == 3'b100)
                    cmd = 3'($urandom_range(0, 7));
            end
            h = {$urandom, $urandom};
            h[63:61] = cmd;
            for (int k = 0; k < 16; k++) pt.wri[32*k +: 32] = $urandom;
            pt.hdr      = h;
            pt.is_wri   = (cmd == 3'b100);
            pt.legal    = (cmd == 3'b001) || (cmd == 3'b010) || (cmd == 3'b100);
            pt.wr8      = (cmd == 3'b010) ? pt.wri[511:448] : 64'd0;
            pt.complete = 1'b1;
            nb = (cmd == 3'b010) ? 2 : (cmd == 3'b100) ? 16 : 0;
            pk.push_back(pt);
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                s_vld.push_back(1'b0); s_req.push_back($urandom);
                s_commit.push_back(-1); s_beat.push_back(-1);
            end
            s_vld.push_back(1'b1); s_req.push_back($urandom);
            s_commit.push_back(-1); s_beat.push_back(-1);
            s_vld.push_back(1'b0); s_req.push_back(h[63:32]);
            s_commit.push_back(-1); s_beat.push_back(-1);
            s_vld.push_back(1'b0); s_req.push_back(h[31:0]);
            s_commit.push_back(-1); s_beat.push_back(-1);
            s_vld.push_back(1'b0); s_req.push_back($urandom);
            s_commit.push_back(-1); s_beat.push_back(-1);
            for (int k = 0; k < nb; k++) begin
                s_vld.push_back(1'b0); s_req.push_back(pt.wri[511-32*k -: 32]);
                s_commit.push_back(-1); s_beat.push_back(pt.is_wri ? p : -1);
            end
            s_vld.push_back(1'b0); s_req.push_back($urandom);
            s_commit.push_back(p); s_beat.push_back(-1);
        end
        for (int g = 0; g < 30; g++) begin
            s_vld.push_back(1'b0); s_req.push_back($urandom);
            s_commit.push_back(-1); s_beat.push_back(-1);
        end

        m_err = 1'b0; m_iqdq = 1'b0; m_wibdq = 1'b0;
        for (int c = 0; c < s_vld.size(); c++) begin
            logic pop;
            logic head_wri;
            logic push;
            int   nwri;
            int   bias;
            tick();
            bias = (c < s_vld.size() / 2) ? 1 : 3;
            vld  = s_vld[c];
            req  = s_req[c];
            rdy  = ($urandom_range(0, 3) < bias);

            chk("rnd_vld",   o_vld,   mq.size() > 0);
            chk("rnd_iqdq",  o_iqdq,  m_iqdq);
            chk("rnd_wibdq", o_wibdq, m_wibdq);
            chk("rnd_err",   o_err,   m_err);
            if (mq.size() > 0) begin
                chk("rnd_hdr", o_hdr, mq[0].hdr);
                chk("rnd_wr8", o_wr8, mq[0].wr8);
                if (!mq[0].is_wri)       chk("rnd_wri0", o_wri, 512'd0);
                else if (mq[0].complete) chk("rnd_wri",  o_wri, mq[0].wri);
            end else begin
                chk("rnd_hdr0", o_hdr, 64'd0);
            end

            // Model step: WIB occupancy equals queued WRI entries
            pop      = (mq.size() > 0) && rdy;
            head_wri = pop && mq[0].is_wri;
            nwri     = 0;
            foreach (mq[j]) nwri += int'(mq[j].is_wri);
            if (s_beat[c] >= 0 && nwri == WIB_D) pk[s_beat[c]].complete = 1'b0;
            push = 1'b0;
            if (s_commit[c] >= 0) begin
                pkt_t cp;
                cp = pk[s_commit[c]];
                if (cp.legal && (mq.size() < IQ_D || pop) &&
                    (!cp.is_wri || nwri < WIB_D || head_wri))
                    push = 1'b1;
                else
                    m_err = 1'b1;
            end
            m_iqdq  = pop && !mq[0].is_wri;
            m_wibdq = head_wri;
            if (pop)  void'(mq.pop_front());
            if (push) mq.push_back(pk[s_commit[c]]);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
